// File: rtl/flip_icon_mem.sv
// Flip-icon store: loads icons from a valid/ready stream, then answers flip_engine reads one cycle later.
// Optional FLIP_ICON_MEM_OOR_CHECK_EN adds a sticky out-of-range read flag oor_err_o.
module flip_icon_mem #(
    parameter int NUM_SPIN             = 256,
    parameter int FLIP_ICON_DEPTH      = 1024,
    parameter int FLIP_ICON_ADDR_DEPTH = $clog2(FLIP_ICON_DEPTH)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            en_i,
    input  logic                            flush_i,
    input  logic                            load_start_i,
    input  logic                            icon_valid_i,
    input  logic [NUM_SPIN-1:0]             icon_i,
    input  logic                            icon_last_i,
    output logic                            icon_ready_o,
    output logic                            load_done_o,
    input  logic                            flip_ren_i,
    input  logic [FLIP_ICON_ADDR_DEPTH:0]   flip_raddr_i,
    output logic [NUM_SPIN-1:0]             flip_rdata_o,
    output logic [FLIP_ICON_ADDR_DEPTH:0]   icon_last_raddr_plus_one_o
`ifdef FLIP_ICON_MEM_OOR_CHECK_EN
    ,
    output logic                            oor_err_o
`endif
);

    localparam int AW = FLIP_ICON_ADDR_DEPTH;
    // One extra bit so a completely full store (count == DEPTH) is representable.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(FLIP_ICON_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;

    logic [1:0]          state;
    logic [AW:0]         wptr;
    logic [AW:0]         count;
    logic [AW:0]         wptr_inc;
    logic [NUM_SPIN-1:0] mem [FLIP_ICON_DEPTH];

    logic in_load;
    logic in_serve;
    logic wr_fire;
    logic rd_fire;
    logic load_entry;

    assign in_load  = (state == LOAD);
    assign in_serve = (state == SERVE);
    assign wptr_inc = wptr + 1'b1;

    assign icon_ready_o               = en_i & in_load & (wptr < DEPTH_W);
    assign load_done_o                = in_serve;
    assign icon_last_raddr_plus_one_o = count;

    // Flush beats a restart, and a restart beats both a write and a read in the same cycle.
    assign wr_fire    = icon_valid_i & icon_ready_o & ~flush_i & ~load_start_i;
    assign rd_fire    = en_i & in_serve & flip_ren_i & ~flush_i & ~load_start_i;
    assign load_entry = en_i & ~flush_i & load_start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            wptr  <= '0;
            count <= '0;
        end else if (en_i) begin
            if (flush_i) begin
                // Icons survive a flush in SERVE; only an unfinished load is discarded.
                if (in_load) begin
                    state <= IDLE;
                    wptr  <= '0;
                    count <= '0;
                end
            end else if (load_start_i) begin
                state <= LOAD;
                wptr  <= '0;
                count <= '0;
            end else if (wr_fire) begin
                wptr <= wptr_inc;
                if (icon_last_i || (wptr_inc == DEPTH_W)) begin
                    state <= SERVE;
                    count <= wptr_inc;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[wptr[AW-1:0]] <= icon_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flip_rdata_o <= '0;
        end else if (en_i) begin
            if (flush_i) begin
                flip_rdata_o <= '0;
            end else if (rd_fire) begin
                flip_rdata_o <= (flip_raddr_i < count) ? mem[flip_raddr_i[AW-1:0]] : '0;
            end
        end
    end

`ifdef FLIP_ICON_MEM_OOR_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oor_err_o <= 1'b0;
        end else if (en_i) begin
            if (flush_i || load_entry) begin
                oor_err_o <= 1'b0;
            end else if ((rd_fire && (flip_raddr_i >= count)) || (flip_ren_i && !in_serve)) begin
                oor_err_o <= 1'b1;
            end
        end
    end
`else
    logic unused_load_entry;
    assign unused_load_entry = load_entry;
`endif

endmodule

// File: tb/tb_flip_icon_mem.sv
// Directed bench for flip_icon_mem with a transaction-level model checked on every falling edge.
// Build with FLIP_ICON_MEM_OOR_CHECK_EN defined to also check oor_err_o.
module tb_flip_icon_mem;

    localparam int NS = 32;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          en_i;
    logic          flush_i;
    logic          load_start_i;
    logic          icon_valid_i;
    logic [NS-1:0] icon_i;
    logic          icon_last_i;
    logic          icon_ready_o;
    logic          load_done_o;
    logic          flip_ren_i;
    logic [AW:0]   flip_raddr_i;
    logic [NS-1:0] flip_rdata_o;
    logic [AW:0]   cnt_o;
`ifdef FLIP_ICON_MEM_OOR_CHECK_EN
    logic          oor_err_o;
`endif

    flip_icon_mem #(
        .NUM_SPIN        (NS),
        .FLIP_ICON_DEPTH (D)
    ) dut (
        .clk_i                      (clk_i),
        .rst_ni                     (rst_ni),
        .en_i                       (en_i),
        .flush_i                    (flush_i),
        .load_start_i               (load_start_i),
        .icon_valid_i               (icon_valid_i),
        .icon_i                     (icon_i),
        .icon_last_i                (icon_last_i),
        .icon_ready_o               (icon_ready_o),
        .load_done_o                (load_done_o),
        .flip_ren_i                 (flip_ren_i),
        .flip_raddr_i               (flip_raddr_i),
        .flip_rdata_o               (flip_rdata_o),
        .icon_last_raddr_plus_one_o (cnt_o)
`ifdef FLIP_ICON_MEM_OOR_CHECK_EN
        ,
        .oor_err_o                  (oor_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Model: mode 0=idle, 1=loading, 2=serving; icons accepted so far; published count.
    logic [NS-1:0] mdl_mem [D];
    int            mode;
    int            nload;
    int            exp_count;
    logic [NS-1:0] exp_rdata;
    bit            exp_oor;
    bit            chk_on = 1'b0;

    localparam logic [NS-1:0] IA = 32'hA1A1_0001;
    localparam logic [NS-1:0] IB = 32'hB2B2_0002;
    localparam logic [NS-1:0] IC = 32'hC3C3_0003;
    localparam logic [NS-1:0] ID = 32'hD4D4_0004;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_on) begin
            chk("icon_ready", 64'(icon_ready_o), 64'(en_i && mode == 1 && nload < D));
            chk("load_done", 64'(load_done_o), 64'(mode == 2));
            chk("count", 64'(cnt_o), 64'(exp_count));
            chk("rdata", 64'(flip_rdata_o), 64'(exp_rdata));
`ifdef FLIP_ICON_MEM_OOR_CHECK_EN
            chk("oor_err", 64'(oor_err_o), 64'(exp_oor));
`endif
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_load();
        load_start_i = 1'b1;
        step();
        load_start_i = 1'b0;
        mode      = 1;
        nload     = 0;
        exp_count = 0;
        exp_oor   = 1'b0;
    endtask

    task automatic push(input logic [NS-1:0] data, input bit last);
        icon_valid_i = 1'b1;
        icon_i       = data;
        icon_last_i  = last;
        step();
        icon_valid_i = 1'b0;
        icon_last_i  = 1'b0;
        mdl_mem[nload] = data;
        nload++;
        if (last || nload == D) begin
            mode      = 2;
            exp_count = nload;
        end
    endtask

    task automatic rd(input int addr);
        flip_ren_i   = 1'b1;
        flip_raddr_i = (AW+1)'(addr);
        step();
        flip_ren_i = 1'b0;
        if (mode == 2) begin
            if (addr < exp_count) begin
                exp_rdata = mdl_mem[addr];
            end else begin
                exp_rdata = '0;
                exp_oor   = 1'b1;
            end
        end else begin
            exp_oor = 1'b1;
        end
    endtask

    task automatic flush();
        flush_i = 1'b1;
        step();
        flush_i   = 1'b0;
        exp_rdata = '0;
        exp_oor   = 1'b0;
        if (mode == 1) begin
            mode      = 0;
            exp_count = 0;
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        en_i         = 1'b1;
        flush_i      = 1'b0;
        load_start_i = 1'b0;
        icon_valid_i = 1'b0;
        icon_i       = '0;
        icon_last_i  = 1'b0;
        flip_ren_i   = 1'b0;
        flip_raddr_i = '0;
        mode         = 0;
        nload        = 0;
        exp_count    = 0;
        exp_rdata    = '0;
        exp_oor      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_on = 1'b1;
        rst_ni = 1'b1;
        step();

        // Four-icon load, then single, out-of-range and back-to-back reads.
        start_load();
        push(IA, 0); push(IB, 0); push(IC, 0); push(ID, 1);
        chk("lit_count4", 64'(cnt_o), 64'd4);
        rd(2);
        chk("lit_rd2", 64'(flip_rdata_o), 64'(IC));
        rd(5);
        chk("lit_rd5", 64'(flip_rdata_o), 64'd0);
`ifdef FLIP_ICON_MEM_OOR_CHECK_EN
        chk("lit_oor", 64'(oor_err_o), 64'd1);
`endif
        for (int i = 0; i < 4; i++) rd(i);
        chk("lit_rd3_b2b", 64'(flip_rdata_o), 64'(ID));

        // Flush in SERVE keeps the icons.
        flush();
        chk("lit_flush_rdata", 64'(flip_rdata_o), 64'd0);
        chk("lit_flush_count", 64'(cnt_o), 64'd4);
        rd(1);
        chk("lit_reread", 64'(flip_rdata_o), 64'(IB));

        // Flush mid-load aborts; a read in IDLE is ignored.
        start_load();
        push(32'hE000_0000, 0); push(32'hE000_0001, 0);
        flush();
        chk("lit_abort_count", 64'(cnt_o), 64'd0);
        chk("lit_abort_done", 64'(load_done_o), 64'd0);
        rd(0);

        // Fill to DEPTH without a last marker.
        start_load();
        for (int i = 0; i < D; i++) push(32'hD000_0000 + NS'(i), 0);
        chk("lit_full_count", 64'(cnt_o), 64'(D));
        chk("lit_full_ready", 64'(icon_ready_o), 64'd0);
        icon_valid_i = 1'b1;
        icon_i       = 32'hFFFF_FFFF;
        step();
        icon_valid_i = 1'b0;
        rd(D - 1);
        chk("lit_rd_last", 64'(flip_rdata_o), 64'h0000_0000_D000_000F);
        rd(D);
        rd(3);

        // Restart together with a read: read dropped, rdata holds.
        load_start_i = 1'b1;
        flip_ren_i   = 1'b1;
        flip_raddr_i = 5'd4;
        step();
        load_start_i = 1'b0;
        flip_ren_i   = 1'b0;
        mode = 1; nload = 0; exp_count = 0; exp_oor = 1'b0;
        chk("lit_restart_hold", 64'(flip_rdata_o), 64'h0000_0000_D000_0003);

        // Asynchronous reset mid-load.
        push(32'hF000_0000, 0); push(32'hF000_0001, 0);
        rst_ni = 1'b0;
        #1;
        mode = 0; nload = 0; exp_count = 0; exp_rdata = '0; exp_oor = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("lit_rst_rdata", 64'(flip_rdata_o), 64'd0);
        chk("lit_rst_count", 64'(cnt_o), 64'd0);

        // en_i low freezes loading and serving.
        start_load();
        push(32'h6000_0000, 0);
        en_i         = 1'b0;
        icon_valid_i = 1'b1;
        icon_i       = 32'h6666_6666;
        step();
        icon_valid_i = 1'b0;
        en_i         = 1'b1;
        push(32'h6000_0001, 0); push(32'h6000_0002, 1);
        chk("lit_en_count", 64'(cnt_o), 64'd3);
        rd(1);
        chk("lit_en_rd1", 64'(flip_rdata_o), 64'h0000_0000_6000_0001);
        en_i         = 1'b0;
        flip_ren_i   = 1'b1;
        flip_raddr_i = 5'd2;
        step();
        flush_i = 1'b1;
        step();
        load_start_i = 1'b1;
        step();
        load_start_i = 1'b0;
        flush_i      = 1'b0;
        flip_ren_i   = 1'b0;
        chk("lit_en_hold", 64'(flip_rdata_o), 64'h0000_0000_6000_0001);
        en_i = 1'b1;
        step();
        rd(2);
        chk("lit_en_rd2", 64'(flip_rdata_o), 64'h0000_0000_6000_0002);
        step();

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
